qosc_ctrl: RTL and testbench



---
 rtl/qosc_pkg.sv | 45 ++++
 rtl/qosc_ctrl_if.sv | 11 +
 rtl/qosc_frame_rx.sv | 92 +++++++++
 rtl/qosc_ctrl.sv | 176 +++++++++++++++++
 tb/tb_qosc_ctrl.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/qosc_pkg.sv
// qosc_pkg: shared types and constants for the quadrature oscillator
// configuration controller.
// Optional feature macro: QOSC_CTRL_CHECKSUM_EN (adds an XOR check byte
// at the end of each frame).
package qosc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RX   = 2'd1,
    ST_LOAD = 2'd2,
    ST_RUN  = 2'd3
  } qosc_state_e;

  localparam int QOSC_WORDS         = 5;
  localparam int QOSC_PAYLOAD_BYTES = 10;

  // Byte positions of each oscillator word inside the frame (little-endian).
  localparam int IDX_RE_LO  = 0;
  localparam int IDX_RE_HI  = 1;
  localparam int IDX_IM_LO  = 2;
  localparam int IDX_IM_HI  = 3;
  localparam int IDX_PW_LO  = 4;
  localparam int IDX_PW_HI  = 5;
  localparam int IDX_ARE_LO = 6;
  localparam int IDX_ARE_HI = 7;
  localparam int IDX_AIM_LO = 8;
  localparam int IDX_AIM_HI = 9;

`ifdef QOSC_CTRL_CHECKSUM_EN
  localparam int QOSC_FRAME_BYTES = QOSC_PAYLOAD_BYTES + 1;
`else
  localparam int QOSC_FRAME_BYTES = QOSC_PAYLOAD_BYTES;
`endif

  typedef logic [QOSC_PAYLOAD_BYTES-1:0][7:0] qosc_payload_t;
  typedef logic [QOSC_WORDS-1:0][15:0]        qosc_words_t;

  // Assemble one 16-bit word from its lo/hi byte positions.
  function automatic logic [15:0] qosc_word(input qosc_payload_t p,
                                            input int lo_idx,
                                            input int hi_idx);
    return {p[hi_idx], p[lo_idx]};
  endfunction

endpackage

// File: rtl/qosc_ctrl_if.sv
// qosc_ctrl_if: byte-serial configuration port (valid/ready handshake).
// The master drives bytes, the slave (qosc_ctrl) returns ready.
interface qosc_ctrl_if;
  logic [7:0] cfg_data;
  logic       cfg_valid;
  logic       cfg_start;
  logic       cfg_ready;

  modport master (output cfg_data, output cfg_valid, output cfg_start, input cfg_ready);
  modport slave  (input cfg_data, input cfg_valid, input cfg_start, output cfg_ready);
endinterface

// File: rtl/qosc_frame_rx.sv
// qosc_frame_rx: byte index counter and shadow registers for one frame.
// With QOSC_CTRL_CHECKSUM_EN a running XOR of the payload is kept and the
// final byte is compared against it instead of being stored.
// shadow is the next-state view so the last payload byte is visible in the
// same cycle frame_done is flagged.
module qosc_frame_rx
  import qosc_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          acc,        // byte accepted this cycle
  input  logic          start,      // accepted byte is byte 0 of a frame
  input  logic [7:0]    data,
  input  logic          rx_active,  // controller is collecting a frame
  output qosc_payload_t shadow,
  output logic          frame_done,
  output logic          frame_bad
);

  localparam logic [3:0] LAST_IDX    = 4'(QOSC_FRAME_BYTES - 1);
  localparam logic [3:0] PAYLOAD_END = 4'(QOSC_PAYLOAD_BYTES);

  logic [3:0]    idx_q, idx_d;
  qosc_payload_t shadow_q, shadow_d;
  logic          frame_done_s;
  logic          frame_bad_s;
`ifdef QOSC_CTRL_CHECKSUM_EN
  logic [7:0]    xor_q, xor_d;
`endif

  // Index/shadow update: a start byte always opens a fresh frame.
  always_comb begin
    idx_d        = idx_q;
    shadow_d     = shadow_q;
    frame_done_s = 1'b0;
    frame_bad_s  = 1'b0;
`ifdef QOSC_CTRL_CHECKSUM_EN
    xor_d        = xor_q;
`endif
    if (acc && start) begin
      idx_d       = 4'd1;
      shadow_d[0] = data;
`ifdef QOSC_CTRL_CHECKSUM_EN
      xor_d       = data;
`endif
    end else if (acc && rx_active) begin
      if (idx_q < PAYLOAD_END) begin
        shadow_d[idx_q] = data;
      end else begin
        shadow_d = shadow_q;
      end
`ifdef QOSC_CTRL_CHECKSUM_EN
      xor_d = xor_q ^ data;
`endif
      if (idx_q == LAST_IDX) begin
        idx_d        = 4'd0;
        frame_done_s = 1'b1;
`ifdef QOSC_CTRL_CHECKSUM_EN
        frame_bad_s  = (data != xor_q);
`else
        frame_bad_s  = 1'b0;
`endif
      end else begin
        idx_d = idx_q + 4'd1;
      end
    end else begin
      idx_d = idx_q;
    end
  end

  // Frame assembly registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q    <= 4'd0;
      shadow_q <= '0;
`ifdef QOSC_CTRL_CHECKSUM_EN
      xor_q    <= 8'h00;
`endif
    end else begin
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
`ifdef QOSC_CTRL_CHECKSUM_EN
      xor_q    <= xor_d;
`endif
    end
  end

  assign shadow     = shadow_d;
  assign frame_done = frame_done_s;
  assign frame_bad  = frame_bad_s;

endmodule

// File: rtl/qosc_ctrl.sv
// qosc_ctrl: configuration/sequencing controller for the quadrature
// oscillator. Collects a byte frame, commits the five words atomically and
// strobes load for LOAD_CYCLES cycles (1..15).
// Optional feature macro: QOSC_CTRL_CHECKSUM_EN.
module qosc_ctrl
  import qosc_pkg::*;
#(
  parameter int unsigned LOAD_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  qosc_ctrl_if.slave  cfg,
  input  logic        restart,
  input  logic        err_clr,
  output logic        load,
  output logic [15:0] re_coeff,
  output logic [15:0] im_coeff,
  output logic [15:0] power,
  output logic [15:0] accu_re_init,
  output logic [15:0] accu_im_init,
  output logic        configured,
  output logic        busy,
  output logic        err
);

  localparam logic [3:0] LOAD_CNT_INIT = 4'(LOAD_CYCLES - 1);

  qosc_state_e   state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  qosc_words_t   words_q, words_d;
  logic          load_q, load_d;
  logic          ready_q, ready_d;
  logic          busy_q, busy_d;
  logic          configured_q, configured_d;
  logic          err_q, err_d;

  logic          acc_s;
  logic          rx_s;
  logic          commit_s;
  logic          abort_s;
  logic          bad_s;
  qosc_payload_t shadow_s;
  logic          frame_done_s;
  logic          frame_bad_s;

  assign acc_s = cfg.cfg_valid & ready_q;
  assign rx_s  = (state_q == ST_RX);

  qosc_frame_rx u_frame_rx (
    .clk        (clk),
    .rst_n      (rst_n),
    .acc        (acc_s),
    .start      (cfg.cfg_start),
    .data       (cfg.cfg_data),
    .rx_active  (rx_s),
    .shadow     (shadow_s),
    .frame_done (frame_done_s),
    .frame_bad  (frame_bad_s)
  );

  // Next-state logic; start bytes take priority over restart and frame end.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    commit_s = 1'b0;
    abort_s  = 1'b0;
    bad_s    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (acc_s && cfg.cfg_start) begin
          state_d = ST_RX;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RX: begin
        if (acc_s && cfg.cfg_start) begin
          abort_s = 1'b1;
        end else if (frame_done_s && frame_bad_s) begin
          bad_s   = 1'b1;
          state_d = configured_q ? ST_RUN : ST_IDLE;
        end else if (frame_done_s) begin
          commit_s = 1'b1;
          cnt_d    = LOAD_CNT_INIT;
          state_d  = ST_LOAD;
        end else begin
          state_d = ST_RX;
        end
      end
      ST_LOAD: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RUN: begin
        if (acc_s && cfg.cfg_start) begin
          state_d = ST_RX;
        end else if (restart) begin
          cnt_d   = LOAD_CNT_INIT;
          state_d = ST_LOAD;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Next values of the registered outputs, derived from the next state.
  always_comb begin
    words_d = words_q;
    if (commit_s) begin
      words_d[0] = qosc_word(shadow_s, IDX_RE_LO,  IDX_RE_HI);
      words_d[1] = qosc_word(shadow_s, IDX_IM_LO,  IDX_IM_HI);
      words_d[2] = qosc_word(shadow_s, IDX_PW_LO,  IDX_PW_HI);
      words_d[3] = qosc_word(shadow_s, IDX_ARE_LO, IDX_ARE_HI);
      words_d[4] = qosc_word(shadow_s, IDX_AIM_LO, IDX_AIM_HI);
    end else begin
      words_d = words_q;
    end
    configured_d = configured_q | commit_s;
    if (abort_s || bad_s) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
    // Until the first commit the oscillator stays preloaded, even while a
    // frame is being received.
    load_d  = (state_d == ST_IDLE) || (state_d == ST_LOAD) ||
              ((state_d == ST_RX) && !configured_d);
    ready_d = (state_d != ST_LOAD);
    busy_d  = (state_d == ST_RX) || (state_d == ST_LOAD);
  end

  // State, counter and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 4'd0;
      words_q      <= '0;
      load_q       <= 1'b1;
      ready_q      <= 1'b1;
      busy_q       <= 1'b0;
      configured_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      words_q      <= words_d;
      load_q       <= load_d;
      ready_q      <= ready_d;
      busy_q       <= busy_d;
      configured_q <= configured_d;
      err_q        <= err_d;
    end
  end

  assign cfg.cfg_ready  = ready_q;
  assign load           = load_q;
  assign re_coeff       = words_q[0];
  assign im_coeff       = words_q[1];
  assign power          = words_q[2];
  assign accu_re_init   = words_q[3];
  assign accu_im_init   = words_q[4];
  assign configured     = configured_q;
  assign busy           = busy_q;
  assign err            = err_q;

endmodule

// File: tb/tb_qosc_ctrl.sv
// tb_qosc_ctrl: directed + randomized bench for qosc_ctrl against a
// frame-level reference model (byte queue, load countdown, flags).
module tb_qosc_ctrl;

  localparam int LOADC = 2;
`ifdef QOSC_CTRL_CHECKSUM_EN
  localparam int FLEN = 11;
`else
  localparam int FLEN = 10;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        restart, err_clr, load, configured, busy, err;
  logic [15:0] re_coeff, im_coeff, power, accu_re_init, accu_im_init;

  qosc_ctrl_if cfg_if ();

  qosc_ctrl #(.LOAD_CYCLES(LOADC)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg          (cfg_if),
    .restart      (restart),
    .err_clr      (err_clr),
    .load         (load),
    .re_coeff     (re_coeff),
    .im_coeff     (im_coeff),
    .power        (power),
    .accu_re_init (accu_re_init),
    .accu_im_init (accu_im_init),
    .configured   (configured),
    .busy         (busy),
    .err          (err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model
  logic [7:0]  m_frame[$];
  bit          m_open;
  int          m_left;
  bit          m_cfg;
  bit          m_err;
  logic [15:0] m_words[5];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_frame.delete();
    m_open = 1'b0;
    m_left = 0;
    m_cfg  = 1'b0;
    m_err  = 1'b0;
    for (int w = 0; w < 5; w++) m_words[w] = 16'h0000;
  endtask

  task automatic model_step(input bit v, input bit s, input logic [7:0] d,
                            input bit r, input bit c);
    bit         acc;
    bit         nerr;
    bit         ok;
    logic [7:0] x;
    acc  = v && (m_left == 0);
    nerr = 1'b0;
    if (m_left > 0) begin
      m_left--;
    end else if (acc && s) begin
      if (m_open) nerr = 1'b1;
      m_frame.delete();
      m_frame.push_back(d);
      m_open = 1'b1;
    end else if (acc && m_open) begin
      m_frame.push_back(d);
      if (m_frame.size() == FLEN) begin
        ok = 1'b1;
        x  = 8'h00;
        for (int i = 0; i < 10; i++) x ^= m_frame[i];
        if (FLEN == 11) ok = (x == m_frame[10]);
        m_open = 1'b0;
        if (ok) begin
          for (int w = 0; w < 5; w++) m_words[w] = {m_frame[2*w+1], m_frame[2*w]};
          m_cfg  = 1'b1;
          m_left = LOADC;
        end else begin
          nerr = 1'b1;
        end
      end
    end else if (!m_open && m_cfg && r) begin
      m_left = LOADC;
    end
    if (nerr) m_err = 1'b1;
    else if (c) m_err = 1'b0;
  endtask

  task automatic check_all();
    chk("load",       load,             (m_left > 0) || !m_cfg);
    chk("cfg_ready",  cfg_if.cfg_ready, m_left == 0);
    chk("busy",       busy,             m_open || (m_left > 0));
    chk("configured", configured,       m_cfg);
    chk("err",        err,              m_err);
    chk("re_coeff",   re_coeff,         m_words[0]);
    chk("im_coeff",   im_coeff,         m_words[1]);
    chk("power",      power,            m_words[2]);
    chk("accu_re",    accu_re_init,     m_words[3]);
    chk("accu_im",    accu_im_init,     m_words[4]);
  endtask

  task automatic cycle(input bit v, input bit s, input logic [7:0] d,
                       input bit r, input bit c);
    cfg_if.cfg_valid = v;
    cfg_if.cfg_start = s;
    cfg_if.cfg_data  = d;
    restart          = r;
    err_clr          = c;
    @(posedge clk);
    model_step(v, s, d, r, c);
    @(negedge clk);
    check_all();
  endtask

  task automatic send_byte(input logic [7:0] d, input bit s);
    for (int k = 0; k < 20 && m_left > 0; k++) cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    if (m_left > 0) chk("ready_wait", m_left, 0);
    cycle(1'b1, s, d, 1'b0, 1'b0);
  endtask

  task automatic send_range(input logic [79:0] f, input int lo, input int hi);
    for (int i = lo; i < hi; i++) send_byte(f[8*i +: 8], i == 0);
  endtask

  // Sends the check byte when frames carry one; bad flips every bit of it.
  task automatic send_ck(input logic [79:0] f, input bit bad);
    logic [7:0] x;
    x = {8{bad}};
    for (int i = 0; i < 10; i++) x ^= f[8*i +: 8];
    if (FLEN == 11) send_byte(x, 1'b0);
  endtask

  task automatic send_frame(input logic [79:0] f);
    send_range(f, 0, 10);
    send_ck(f, 1'b0);
  endtask

  task automatic count_load(output int n);
    n = 0;
    for (int k = 0; k < 20; k++) begin
      if (load !== 1'b1) break;
      n++;
      cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    end
  endtask

  logic [79:0] f;
  int          n;
  logic [7:0]  rd;
  bit          rv, rs, rr, rc;

  initial begin
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_start = 1'b0;
    cfg_if.cfg_data  = 8'h00;
    restart = 1'b0;
    err_clr = 1'b0;
    rst_n   = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_load",  load, 1);
    chk("rst_ready", cfg_if.cfg_ready, 1);
    chk("rst_busy",  busy, 0);
    chk("rst_cfg",   configured, 0);
    chk("rst_err",   err, 0);
    chk("rst_re",    re_coeff, 0);
    chk("rst_aim",   accu_im_init, 0);
    rst_n = 1'b1;
    repeat (2) cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

    // basic frame, then load pulse width
    f = 80'h0000_4001_9ABC_5678_1234;
    send_frame(f);
    chk("f1_re",  re_coeff, 16'h1234);
    chk("f1_im",  im_coeff, 16'h5678);
    chk("f1_pw",  power, 16'h9ABC);
    chk("f1_are", accu_re_init, 16'h4001);
    chk("f1_aim", accu_im_init, 16'h0000);
    chk("f1_cfg", configured, 1);
    count_load(n);
    chk("f1_load_len", n, LOADC);
    chk("f1_run_load", load, 0);

    // aborted frame, then a full one
    f = 80'hAAAA_BBBB_CCCC_DDDD_EEEE;
    send_range(f, 0, 4);
    chk("abort_hold", re_coeff, 16'h1234);
    f = 80'h1111_2222_3333_4444_5555;
    send_frame(f);
    chk("abort_err", err, 1);
    chk("f2_re",  re_coeff, 16'h5555);
    chk("f2_aim", accu_im_init, 16'h1111);
    count_load(n);
    chk("f2_load_len", n, LOADC);

    // restart in RUN
    cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    count_load(n);
    chk("restart_len", n, LOADC);
    chk("restart_words", power, 16'h3333);

    // restart during RX is ignored
    f = 80'h0F0F_1E1E_2D2D_3C3C_4B4B;
    send_range(f, 0, 4);
    cycle(1'b1, 1'b0, f[39:32], 1'b1, 1'b0);
    chk("rx_restart_load", load, 0);
    send_range(f, 5, 10);
    send_ck(f, 1'b0);
    chk("f3_im", im_coeff, 16'h3C3C);
    count_load(n);

    // err_clr alone, then err_clr together with an abort
    cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    chk("err_clr", err, 0);
    f = 80'h9999_8888_7777_6666_5A5A;
    send_range(f, 0, 3);
    cycle(1'b1, 1'b1, 8'h5A, 1'b0, 1'b1);
    chk("err_wins", err, 1);
    send_range(f, 1, 10);
    send_ck(f, 1'b0);
    chk("f4_re", re_coeff, 16'h5A5A);
    count_load(n);

`ifdef QOSC_CTRL_CHECKSUM_EN
    cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    f = 80'hDEAD_BEEF_CAFE_F00D_ABCD;
    send_range(f, 0, 10);
    send_ck(f, 1'b1);
    chk("ck_bad_err",  err, 1);
    chk("ck_bad_re",   re_coeff, 16'h5A5A);
    chk("ck_bad_busy", busy, 0);
    chk("ck_bad_load", load, 0);
`endif

    // valid held high during LOAD
    f = 80'h1357_2468_0ACE_BDF1_7777;
    send_frame(f);
    cycle(1'b1, 1'b0, 8'hAA, 1'b0, 1'b0);
    chk("ready_in_load", cfg_if.cfg_ready, 0);
    repeat (3) cycle(1'b1, 1'b0, 8'hAA, 1'b0, 1'b0);
    chk("no_consume_busy", busy, 0);
    chk("no_consume_re", re_coeff, 16'h7777);

    // reset in the middle of LOAD
    f = 80'h4444_3333_2222_1111_0001;
    send_frame(f);
    cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("midload_rst_load", load, 1);
    chk("midload_rst_re",   re_coeff, 0);
    chk("midload_rst_aim",  accu_im_init, 0);
    chk("midload_rst_cfg",  configured, 0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b1, 1'b0, 8'h77, 1'b0, 1'b0);
    chk("idle_drop_busy", busy, 0);
    chk("idle_drop_load", load, 1);

    // randomized traffic against the model
    for (int t = 0; t < 3000; t++) begin
      rv = ($urandom_range(0, 9) < 7);
      rs = ($urandom_range(0, 99) < 8);
      rd = 8'($urandom);
      rr = ($urandom_range(0, 99) < 5);
      rc = ($urandom_range(0, 99) < 4);
      if (FLEN == 11 && m_open && m_frame.size() == 10 && $urandom_range(0, 1) == 1) begin
        rd = 8'h00;
        for (int i = 0; i < 10; i++) rd ^= m_frame[i];
        rs = 1'b0;
      end
      cycle(rv, rs, rd, rr, rc);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
